// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bundle: two valid/ready writeback sources plus the registered
// regfile write port. The master modport is the requester side, slave is the arbiter.
interface wb_arbiter_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_wen;
  logic        ex_starve;

  modport master (
    output ex_valid, ex_waddr, ex_wdata, lu_valid, lu_waddr, lu_wdata,
    input  ex_ready, lu_ready, reg_waddr, reg_wdata, reg_wen, ex_starve
  );

  modport slave (
    input  ex_valid, ex_waddr, ex_wdata, lu_valid, lu_waddr, lu_wdata,
    output ex_ready, lu_ready, reg_waddr, reg_wdata, reg_wen, ex_starve
  );
endinterface

// File: rtl/wb_arbiter.sv
// Arbitrates the single regfile write port between EX and LU writeback sources.
// LU has default priority; EX gets one forced slot after MAX_WAIT consecutive refusals.
module wb_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StPriLu, StPriEx} state_e;

  localparam logic [CNT_W-1:0] MaxWait = CNT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        reg_waddr_q;
  logic [31:0]       reg_wdata_q;
  logic              reg_wen_q;
  logic              ex_ready, lu_ready;
  logic              ex_accept, lu_accept;

  // Readies are forced low while reset is held so nothing is consumed during reset.
  always_comb begin
    ex_ready = 1'b0;
    lu_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StPriLu: begin
          lu_ready = bus.lu_valid;
          ex_ready = bus.ex_valid & ~bus.lu_valid;
        end
        StPriEx: begin
          ex_ready = bus.ex_valid;
          lu_ready = bus.lu_valid & ~bus.ex_valid;
        end
      endcase
    end
  end

  assign ex_accept = bus.ex_valid & ex_ready;
  assign lu_accept = bus.lu_valid & lu_ready;

  always_comb begin
    cnt_d = '0;
    if (bus.ex_valid && !ex_ready) begin
      cnt_d = (cnt_q == MaxWait) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPriLu: if (cnt_d == MaxWait) state_d = StPriEx;
      // Leave on accept, or recover if EX illegally withdrew its request.
      StPriEx: if (ex_accept || !bus.ex_valid) state_d = StPriLu;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPriLu;
      cnt_q       <= '0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      reg_wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (lu_accept) begin
        reg_waddr_q <= bus.lu_waddr;
        reg_wdata_q <= bus.lu_wdata;
        reg_wen_q   <= |bus.lu_waddr;
      end else if (ex_accept) begin
        reg_waddr_q <= bus.ex_waddr;
        reg_wdata_q <= bus.ex_wdata;
        reg_wen_q   <= |bus.ex_waddr;
      end else begin
        reg_wen_q <= 1'b0;
      end
    end
  end

  assign bus.ex_ready  = ex_ready;
  assign bus.lu_ready  = lu_ready;
  assign bus.reg_waddr = reg_waddr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_wen   = reg_wen_q;
  assign bus.ex_starve = (state_q == StPriEx);

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus a
// per-cycle comparison against a refusal-count model of the arbitration rules.
module tb_wb_arbiter;
  localparam int unsigned MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: EX is owed the slot once it has been refused MAX_WAIT cycles in a row.
  int unsigned m_wait = 0;
  logic        m_wen = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;
  logic        m_pri_ex, m_ex_rdy, m_lu_rdy;

  assign m_pri_ex = (m_wait == MAX_WAIT);
  assign m_ex_rdy = !rst && bus.ex_valid && (m_pri_ex || !bus.lu_valid);
  assign m_lu_rdy = !rst && bus.lu_valid && !(m_pri_ex && bus.ex_valid);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait  <= 0;
      m_wen   <= 1'b0;
      m_waddr <= '0;
      m_wdata <= '0;
    end else begin
      m_wait <= (bus.ex_valid && !m_ex_rdy) ? m_wait + 1 : 0;
      if (m_lu_rdy) begin
        m_waddr <= bus.lu_waddr;
        m_wdata <= bus.lu_wdata;
        m_wen   <= (bus.lu_waddr != 0);
      end else if (m_ex_rdy) begin
        m_waddr <= bus.ex_waddr;
        m_wdata <= bus.ex_wdata;
        m_wen   <= (bus.ex_waddr != 0);
      end else begin
        m_wen <= 1'b0;
      end
    end
  end

  initial begin
    int unsigned dw;
    dw = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dw = 0;
      end else begin
        chk("cmp_ex_ready", bus.ex_ready, m_ex_rdy);
        chk("cmp_lu_ready", bus.lu_ready, m_lu_rdy);
        chk("cmp_ex_starve", bus.ex_starve, m_pri_ex);
        chk("cmp_reg_wen", bus.reg_wen, m_wen);
        chk("cmp_reg_waddr", bus.reg_waddr, m_waddr);
        chk("cmp_reg_wdata", bus.reg_wdata, m_wdata);
        dw = (bus.ex_valid && !bus.ex_ready) ? dw + 1 : 0;
        chk("ex_wait_bound", dw <= MAX_WAIT, 1'b1);
      end
    end
  end

  task automatic drive(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.ex_valid = ev;
    bus.ex_waddr = ea;
    bus.ex_wdata = ed;
    bus.lu_valid = lv;
    bus.lu_waddr = la;
    bus.lu_wdata = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] exp_lu;
    logic [5:0] exp_ex;
    logic       ex_acc, lu_acc;
    exp_lu = 6'b10_1111;
    exp_ex = 6'b01_0000;

    // Reset held with both sources requesting.
    drive(1'b1, 5'd2, 32'hAA, 1'b1, 5'd3, 32'h11);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ex_ready", bus.ex_ready, 1'b0);
    chk("rst_lu_ready", bus.lu_ready, 1'b0);
    chk("rst_reg_wen", bus.reg_wen, 1'b0);
    chk("rst_reg_waddr", bus.reg_waddr, 32'd0);
    chk("rst_reg_wdata", bus.reg_wdata, 32'd0);
    chk("rst_ex_starve", bus.ex_starve, 1'b0);

    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_lu_ready", bus.lu_ready, 1'b1);
    chk("rel_ex_ready", bus.ex_ready, 1'b0);
    step();
    drive(1'b1, 5'd2, 32'hAA, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("rel_wen", bus.reg_wen, 1'b1);
    chk("rel_waddr", bus.reg_waddr, 32'd3);
    chk("rel_wdata", bus.reg_wdata, 32'h11);
    chk("rel_ex_ready", bus.ex_ready, 1'b1);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("rel_ex_waddr", bus.reg_waddr, 32'd2);
    chk("rel_ex_wdata", bus.reg_wdata, 32'hAA);

    // Single EX write.
    step();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("ex_ready", bus.ex_ready, 1'b1);
    chk("ex_idle_wen", bus.reg_wen, 1'b0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("ex_wen", bus.reg_wen, 1'b1);
    chk("ex_waddr", bus.reg_waddr, 32'd5);
    chk("ex_wdata", bus.reg_wdata, 32'hDEADBEEF);

    // Contention: LU every cycle, EX held from cycle 0 until its forced grant in cycle 4.
    for (int i = 0; i < 6; i++) begin
      step();
      drive(i < 5, 5'd7, 32'hE7, 1'b1, 5'(i + 1), 32'(100 + i));
      @(negedge clk);
      chk($sformatf("cont_lu_ready_%0d", i), bus.lu_ready, exp_lu[i]);
      chk($sformatf("cont_ex_ready_%0d", i), bus.ex_ready, exp_ex[i]);
      chk($sformatf("cont_starve_%0d", i), bus.ex_starve, exp_ex[i]);
    end
    chk("cont_ex_out_addr", bus.reg_waddr, 32'd7);
    chk("cont_ex_out_data", bus.reg_wdata, 32'hE7);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("cont_lu_out_addr", bus.reg_waddr, 32'd6);
    chk("cont_lu_out_data", bus.reg_wdata, 32'd105);

    // x0 write is consumed without a write enable.
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
    @(negedge clk);
    chk("x0_lu_ready", bus.lu_ready, 1'b1);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("x0_wen", bus.reg_wen, 1'b0);
    chk("x0_wdata", bus.reg_wdata, 32'h1234);

    // Asynchronous reset while a write is on the port.
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("ar_wen_before", bus.reg_wen, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ar_wen_drop", bus.reg_wen, 1'b0);
    chk("ar_waddr_clr", bus.reg_waddr, 32'd0);
    chk("ar_starve", bus.ex_starve, 1'b0);
    step();
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd8, 32'h88);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_post_lu_ready", bus.lu_ready, 1'b1);
    chk("ar_post_ex_ready", bus.ex_ready, 1'b0);
    chk("ar_post_starve", bus.ex_starve, 1'b0);

    // Random traffic; requests hold steady until accepted.
    for (int n = 0; n < 3000; n++) begin
      ex_acc = bus.ex_valid && bus.ex_ready;
      lu_acc = bus.lu_valid && bus.lu_ready;
      step();
      if (!bus.ex_valid || ex_acc) begin
        bus.ex_valid = ($urandom_range(0, 99) < 60);
        bus.ex_waddr = 5'($urandom_range(0, 31));
        bus.ex_wdata = $urandom;
      end
      if (!bus.lu_valid || lu_acc) begin
        bus.lu_valid = ($urandom_range(0, 99) < 70);
        bus.lu_waddr = 5'($urandom_range(0, 31));
        bus.lu_wdata = $urandom;
      end
      @(negedge clk);
    end

    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
